// File: rtl/gpioemu_pkg.sv
// Shared constants, state encodings and helpers for the gpioemu bus host.
package gpioemu_pkg;

    localparam logic [15:0] ADDR_A1   = 16'h0380;
    localparam logic [15:0] ADDR_A2   = 16'h0388;
    localparam logic [15:0] ADDR_W    = 16'h0390;
    localparam logic [15:0] ADDR_L    = 16'h0398;
    localparam logic [15:0] ADDR_CTRL = 16'h03A0;

    localparam int unsigned STAT_READY = 1;
    localparam int unsigned STAT_FIT   = 0;

    typedef enum logic [2:0] {
        H_IDLE,
        H_WR_A1,
        H_WR_A2,
        H_WR_GO,
        H_POLL,
        H_RD_W,
        H_RD_L,
        H_RESP
    } host_state_t;

    typedef enum logic [1:0] {
        X_IDLE,
        X_SETUP,
        X_STROBE,
        X_HOLD
    } xfer_state_t;

    // Number of set bits in a 32-bit word.
    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + 6'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/gpioemu_bus_xfer.sv
// Single gpioemu bus access: SETUP (1) / STROBE (STROBE_CYCLES) / HOLD (1).
// A new start is accepted in IDLE or in HOLD so accesses can run back-to-back.
module gpioemu_bus_xfer
    import gpioemu_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rnw,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic [15:0] saddress,
    output logic        srd,
    output logic        swr,
    output logic [31:0] sdata_out,
    input  logic [31:0] sdata_in
);

    localparam int unsigned SC_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

    xfer_state_t      state_q, state_d;
    logic [SC_W-1:0]  cnt_q, cnt_d;
    logic             rnw_q, rnw_d;
    logic [15:0]      addr_d;
    logic [31:0]      wdata_d, rdata_d;
    logic             srd_d, swr_d, done_d, busy_d;

    // State and registered bus outputs; reset drops strobes immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= X_IDLE;
            cnt_q     <= '0;
            rnw_q     <= 1'b0;
            saddress  <= '0;
            sdata_out <= '0;
            rdata     <= '0;
            srd       <= 1'b0;
            swr       <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rnw_q     <= rnw_d;
            saddress  <= addr_d;
            sdata_out <= wdata_d;
            rdata     <= rdata_d;
            srd       <= srd_d;
            swr       <= swr_d;
            done      <= done_d;
            busy      <= busy_d;
        end
    end

    // Next-state and next-output logic for one access.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rnw_d   = rnw_q;
        addr_d  = saddress;
        wdata_d = sdata_out;
        rdata_d = rdata;
        srd_d   = 1'b0;
        swr_d   = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            X_IDLE, X_HOLD: begin
                if (start) begin
                    state_d = X_SETUP;
                    rnw_d   = rnw;
                    addr_d  = addr;
                    wdata_d = rnw ? 32'h0 : wdata;
                end else if (state_q == X_HOLD) begin
                    state_d = X_IDLE;
                end
            end
            X_SETUP: begin
                state_d = X_STROBE;
                cnt_d   = '0;
                srd_d   = rnw_q;
                swr_d   = !rnw_q;
            end
            X_STROBE: begin
                if (cnt_q == SC_W'(STROBE_CYCLES - 1)) begin
                    state_d = X_HOLD;
                    done_d  = 1'b1;
                    if (rnw_q) begin
                        rdata_d = sdata_in;
                    end
                end else begin
                    cnt_d = cnt_q + SC_W'(1);
                    srd_d = rnw_q;
                    swr_d = !rnw_q;
                end
            end
            default: state_d = X_IDLE;
        endcase
        busy_d = (state_d != X_IDLE);
    end

endmodule

// File: rtl/gpioemu_host.sv
// gpioemu bus initiator: runs one 24x24 multiply job on the slave per command.
// Optional build macro GPIOEMU_HOST_POPCNT_CHECK_EN adds rsp_lmismatch, a local
// popcount(rsp_w) vs rsp_l cross-check.
module gpioemu_host
    import gpioemu_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 1,
    parameter int unsigned POLL_LIMIT    = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_a1,
    input  logic [23:0] cmd_a2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_w,
    output logic [23:0] rsp_l,
    output logic        rsp_fit,
    output logic        rsp_timeout,
`ifdef GPIOEMU_HOST_POPCNT_CHECK_EN
    output logic        rsp_lmismatch,
`endif
    output logic [15:0] op_count,
    output logic [15:0] saddress,
    output logic        swr,
    output logic        srd,
    output logic [31:0] sdata_out,
    input  logic [31:0] sdata_in
);

    localparam int unsigned PC_W = $clog2(POLL_LIMIT + 1);

    host_state_t      state_q, state_d;
    logic [PC_W-1:0]  poll_q, poll_d, poll_inc;
    logic [23:0]      a2_q, a2_d;
    logic [31:0]      w_d;
    logic [23:0]      l_d;
    logic             fit_d, to_d, rv_d;
    logic [15:0]      op_d;
`ifdef GPIOEMU_HOST_POPCNT_CHECK_EN
    logic             lm_d;
`endif

    logic             xfer_start_c, xfer_rnw_c;
    logic [15:0]      xfer_addr_c;
    logic [31:0]      xfer_wdata_c;
    logic             xfer_busy, xfer_done;
    logic [31:0]      xfer_rdata;

    gpioemu_bus_xfer #(
        .STROBE_CYCLES(STROBE_CYCLES)
    ) u_xfer (
        .clk       (clk),
        .reset     (reset),
        .start     (xfer_start_c),
        .rnw       (xfer_rnw_c),
        .addr      (xfer_addr_c),
        .wdata     (xfer_wdata_c),
        .busy      (xfer_busy),
        .done      (xfer_done),
        .rdata     (xfer_rdata),
        .saddress  (saddress),
        .srd       (srd),
        .swr       (swr),
        .sdata_out (sdata_out),
        .sdata_in  (sdata_in)
    );

    // Job state, poll counter and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= H_IDLE;
            poll_q      <= '0;
            a2_q        <= '0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_w       <= '0;
            rsp_l       <= '0;
            rsp_fit     <= 1'b0;
            rsp_timeout <= 1'b0;
            op_count    <= '0;
`ifdef GPIOEMU_HOST_POPCNT_CHECK_EN
            rsp_lmismatch <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            poll_q      <= poll_d;
            a2_q        <= a2_d;
            cmd_ready   <= (state_d == H_IDLE);
            rsp_valid   <= rv_d;
            rsp_w       <= w_d;
            rsp_l       <= l_d;
            rsp_fit     <= fit_d;
            rsp_timeout <= to_d;
            op_count    <= op_d;
`ifdef GPIOEMU_HOST_POPCNT_CHECK_EN
            rsp_lmismatch <= lm_d;
`endif
        end
    end

    // Saturating poll count increment.
    assign poll_inc = (poll_q == {PC_W{1'b1}}) ? poll_q : poll_q + PC_W'(1);

    // Job sequencing; the next access is launched in the HOLD cycle of the last one.
    always_comb begin
        state_d      = state_q;
        poll_d       = poll_q;
        a2_d         = a2_q;
        w_d          = rsp_w;
        l_d          = rsp_l;
        fit_d        = rsp_fit;
        to_d         = rsp_timeout;
        rv_d         = rsp_valid;
        op_d         = op_count;
`ifdef GPIOEMU_HOST_POPCNT_CHECK_EN
        lm_d         = rsp_lmismatch;
`endif
        xfer_start_c = 1'b0;
        xfer_rnw_c   = 1'b1;
        xfer_addr_c  = ADDR_CTRL;
        xfer_wdata_c = 32'h0;
        unique case (state_q)
            H_IDLE: begin
                if (cmd_valid && cmd_ready && !xfer_busy) begin
                    state_d      = H_WR_A1;
                    a2_d         = cmd_a2;
                    poll_d       = '0;
                    w_d          = '0;
                    l_d          = '0;
                    fit_d        = 1'b0;
                    to_d         = 1'b0;
`ifdef GPIOEMU_HOST_POPCNT_CHECK_EN
                    lm_d         = 1'b0;
`endif
                    xfer_start_c = 1'b1;
                    xfer_rnw_c   = 1'b0;
                    xfer_addr_c  = ADDR_A1;
                    xfer_wdata_c = {8'h0, cmd_a1};
                end
            end
            H_WR_A1: begin
                if (xfer_done) begin
                    state_d      = H_WR_A2;
                    xfer_start_c = 1'b1;
                    xfer_rnw_c   = 1'b0;
                    xfer_addr_c  = ADDR_A2;
                    xfer_wdata_c = {8'h0, a2_q};
                end
            end
            H_WR_A2: begin
                if (xfer_done) begin
                    state_d      = H_WR_GO;
                    xfer_start_c = 1'b1;
                    xfer_rnw_c   = 1'b0;
                    xfer_addr_c  = ADDR_CTRL;
                end
            end
            H_WR_GO: begin
                if (xfer_done) begin
                    state_d      = H_POLL;
                    poll_d       = '0;
                    xfer_start_c = 1'b1;
                end
            end
            H_POLL: begin
                if (xfer_done) begin
                    if (xfer_rdata[STAT_READY]) begin
                        state_d      = H_RD_W;
                        fit_d        = xfer_rdata[STAT_FIT];
                        xfer_start_c = 1'b1;
                        xfer_addr_c  = ADDR_W;
                    end else begin
                        poll_d = poll_inc;
                        if (poll_inc >= PC_W'(POLL_LIMIT)) begin
                            state_d = H_RESP;
                            to_d    = 1'b1;
                            rv_d    = 1'b1;
                        end else begin
                            xfer_start_c = 1'b1;
                        end
                    end
                end
            end
            H_RD_W: begin
                if (xfer_done) begin
                    state_d      = H_RD_L;
                    w_d          = xfer_rdata;
                    xfer_start_c = 1'b1;
                    xfer_addr_c  = ADDR_L;
                end
            end
            H_RD_L: begin
                if (xfer_done) begin
                    state_d = H_RESP;
                    l_d     = xfer_rdata[23:0];
                    rv_d    = 1'b1;
`ifdef GPIOEMU_HOST_POPCNT_CHECK_EN
                    lm_d    = (24'(popcount32(rsp_w)) != xfer_rdata[23:0]);
`endif
                end
            end
            H_RESP: begin
                if (rsp_ready) begin
                    state_d = H_IDLE;
                    rv_d    = 1'b0;
                    if (!rsp_timeout) begin
                        op_d = op_count + 16'd1;
                    end
                end
            end
            default: state_d = H_IDLE;
        endcase
    end

endmodule

// File: tb/tb_gpioemu_host.sv
// Directed bench for gpioemu_host with a behavioural gpioemu slave responder.
module tb_gpioemu_host;
    import gpioemu_pkg::*;

    localparam int unsigned POLL_LIM = 4;
    localparam int LOGMAX = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [23:0] cmd_a1, cmd_a2, rsp_l;
    logic [31:0] rsp_w, sdata_out, sdata_in;
    logic        rsp_fit, rsp_timeout, swr, srd;
    logic [15:0] op_count, saddress;
`ifdef GPIOEMU_HOST_POPCNT_CHECK_EN
    logic        rsp_lmismatch;
`endif

    gpioemu_host #(
        .STROBE_CYCLES(1),
        .POLL_LIMIT   (POLL_LIM)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a1      (cmd_a1),
        .cmd_a2      (cmd_a2),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_w       (rsp_w),
        .rsp_l       (rsp_l),
        .rsp_fit     (rsp_fit),
        .rsp_timeout (rsp_timeout),
`ifdef GPIOEMU_HOST_POPCNT_CHECK_EN
        .rsp_lmismatch(rsp_lmismatch),
`endif
        .op_count    (op_count),
        .saddress    (saddress),
        .swr         (swr),
        .srd         (srd),
        .sdata_out   (sdata_out),
        .sdata_in    (sdata_in)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Responder configuration for the current job.
    int          busy_polls = 0;
    logic        fit_bit = 1'b0;
    logic [31:0] resp_w = '0, resp_l = '0;

    // Bus log: one entry per strobe rising, captured mid-cycle.
    logic [15:0] log_addr [LOGMAX];
    logic        log_we   [LOGMAX];
    logic [31:0] log_data [LOGMAX];
    int          log_n = 0;
    int          polls_seen = 0;
    logic        strobe_prev = 1'b0;
    logic        both_seen = 1'b0;

    always @(negedge clk) begin
        if ((srd || swr) && !strobe_prev && log_n < LOGMAX) begin
            log_addr[log_n] = saddress;
            log_we[log_n]   = swr;
            log_data[log_n] = sdata_out;
            log_n = log_n + 1;
            if (srd && saddress == ADDR_CTRL) polls_seen = polls_seen + 1;
        end
        if (srd && swr) both_seen = 1'b1;
        strobe_prev = srd || swr;
    end

    // Slave read data: status is busy for the first busy_polls reads.
    always @* begin
        case (saddress)
            ADDR_CTRL: sdata_in = (polls_seen <= busy_polls) ? 32'h1 : {30'h0, 1'b1, fit_bit};
            ADDR_W:    sdata_in = resp_w;
            ADDR_L:    sdata_in = resp_l;
            default:   sdata_in = 32'hDEAD_0000;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [23:0] a1;
        logic [23:0] a2;
        int          busy;
        logic        fit;
        logic [31:0] w;
        logic [31:0] l;
        int          hold;
        int          lat;
        int          polls;
        logic        to;
        logic [31:0] ew;
        logic [23:0] el;
        logic        efit;
        logic        elm;
    } vec_t;

    vec_t vecs [6];
    int   exp_op = 0;

    task automatic run_job(input vec_t v, input int idx);
        int  n;
        bit  got;
        bit  bad;
        int  e;
        logic [15:0] ea;
        logic        ewe;
        logic [31:0] ed;
        busy_polls = v.busy;
        fit_bit    = v.fit;
        resp_w     = v.w;
        resp_l     = v.l;
        log_n      = 0;
        polls_seen = 0;

        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) got = 1;
        end
        chk($sformatf("v%0d_cmd_ready_idle", idx), 32'(got), 32'd1);
        cmd_a1 = v.a1;
        cmd_a2 = v.a2;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_a1 = '0;
        cmd_a2 = '0;
        chk($sformatf("v%0d_cmd_ready_busy", idx), 32'(cmd_ready), 32'd0);

        n = 0;
        got = 0;
        while (!got && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (rsp_valid === 1'b1) got = 1;
        end
        chk($sformatf("v%0d_latency", idx), 32'(n), 32'(v.lat));
        chk($sformatf("v%0d_rsp_w", idx), rsp_w, v.ew);
        chk($sformatf("v%0d_rsp_l", idx), 32'(rsp_l), 32'(v.el));
        chk($sformatf("v%0d_rsp_fit", idx), 32'(rsp_fit), 32'(v.efit));
        chk($sformatf("v%0d_rsp_timeout", idx), 32'(rsp_timeout), 32'(v.to));
`ifdef GPIOEMU_HOST_POPCNT_CHECK_EN
        chk($sformatf("v%0d_rsp_lmismatch", idx), 32'(rsp_lmismatch), 32'(v.elm));
`endif

        // Backpressure: response must hold, new commands ignored.
        bad = 0;
        cmd_valid = 1'b1;
        cmd_a1 = 24'h5A5A5A;
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b1 || rsp_w !== v.ew || rsp_l !== v.el ||
                rsp_fit !== v.efit || rsp_timeout !== v.to || cmd_ready !== 1'b0)
                bad = 1;
        end
        if (v.hold > 0) chk($sformatf("v%0d_backpressure_stable", idx), 32'(bad), 32'd0);
        cmd_valid = 1'b0;
        cmd_a1 = '0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        if (!v.to) exp_op++;
        chk($sformatf("v%0d_rsp_valid_drop", idx), 32'(rsp_valid), 32'd0);
        chk($sformatf("v%0d_cmd_ready_after", idx), 32'(cmd_ready), 32'd1);
        chk($sformatf("v%0d_op_count", idx), 32'(op_count), 32'(exp_op));
        chk($sformatf("v%0d_polls", idx), 32'(polls_seen), 32'(v.polls));

        // Expected bus sequence.
        chk($sformatf("v%0d_bus_len", idx), 32'(log_n), 32'(3 + v.polls + (v.to ? 0 : 2)));
        for (int i = 0; i < log_n; i++) begin
            ed = 32'h0;
            if (i == 0)      begin ea = ADDR_A1;   ewe = 1'b1; ed = {8'h0, v.a1}; end
            else if (i == 1) begin ea = ADDR_A2;   ewe = 1'b1; ed = {8'h0, v.a2}; end
            else if (i == 2) begin ea = ADDR_CTRL; ewe = 1'b1; end
            else if (i < 3 + v.polls) begin ea = ADDR_CTRL; ewe = 1'b0; end
            else if (i == 3 + v.polls) begin ea = ADDR_W; ewe = 1'b0; end
            else begin ea = ADDR_L; ewe = 1'b0; end
            e = i;
            chk($sformatf("v%0d_bus%0d_addr", idx, e), 32'(log_addr[i]), 32'(ea));
            chk($sformatf("v%0d_bus%0d_we", idx, e), 32'(log_we[i]), 32'(ewe));
            if (ewe) chk($sformatf("v%0d_bus%0d_wdata", idx, e), log_data[i], ed);
        end
    endtask

    initial begin
        //          a1          a2          busy  fit   w               l               hold lat polls to    ew              el          efit  elm
        vecs[0] = '{24'h000003, 24'h000005, 0,    1'b1, 32'h0000_000F,  32'h0000_0004,  10,  18, 1,    1'b0, 32'h0000_000F,  24'h000004, 1'b1, 1'b0};
        vecs[1] = '{24'hFFFFFF, 24'h000002, 3,    1'b0, 32'h01FF_FFFE,  32'hAB00_0018,  0,   27, 4,    1'b0, 32'h01FF_FFFE,  24'h000018, 1'b0, 1'b0};
        vecs[2] = '{24'h00ABCD, 24'h000010, 1000, 1'b1, 32'h1234_5678,  32'h0000_0005,  2,   21, 4,    1'b1, 32'h0000_0000,  24'h000000, 1'b0, 1'b0};
        vecs[3] = '{24'h000100, 24'h000100, 1,    1'b1, 32'h0001_0000,  32'h0000_0001,  0,   21, 2,    1'b0, 32'h0001_0000,  24'h000001, 1'b1, 1'b0};
        vecs[4] = '{24'hFFFFFF, 24'hFFFFFF, 0,    1'b0, 32'hFFFF_FFFF,  32'h0000_001F,  1,   18, 1,    1'b0, 32'hFFFF_FFFF,  24'h00001F, 1'b0, 1'b1};
        vecs[5] = '{24'hFFFFFF, 24'hFFFFFF, 0,    1'b0, 32'hFFFF_FFFF,  32'h0000_0020,  0,   18, 1,    1'b0, 32'hFFFF_FFFF,  24'h000020, 1'b0, 1'b0};

        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_a1 = '0;
        cmd_a2 = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_strobes", 32'({srd, swr}), 32'd0);
        chk("reset_saddress", 32'(saddress), 32'd0);
        chk("reset_op_count", 32'(op_count), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("release_cmd_ready", 32'(cmd_ready), 32'd1);

        for (int k = 0; k < 6; k++) begin
            run_job(vecs[k], k);
        end

        // Reset during the WR_A2 strobe aborts the job.
        busy_polls = 0;
        log_n = 0;
        polls_seen = 0;
        @(negedge clk);
        cmd_a1 = 24'h000007;
        cmd_a2 = 24'h000009;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        begin
            bit got;
            got = 0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (swr === 1'b1 && saddress == ADDR_A2) got = 1;
            end
            chk("rst_found_a2_strobe", 32'(got), 32'd1);
        end
        reset = 1'b1;
        #1;
        chk("rst_swr_drop", 32'(swr), 32'd0);
        chk("rst_saddress", 32'(saddress), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        exp_op = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_release_cmd_ready", 32'(cmd_ready), 32'd1);
        log_n = 0;
        repeat (30) @(posedge clk);
        #1;
        chk("rst_no_bus_activity", 32'(log_n), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("strobes_never_both", 32'(both_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
